// File: rtl/radix4_booth_mult_param.sv
// Sequential radix-4 (modified Booth) multiplier. Operands are shifted in IN_W bits at a time.
// One Booth digit is retired per clock; the product is exposed whole and as a stepped 16-bit window.
module radix4_booth_mult_param #(
    parameter int WIDTH = 16,
    parameter int IN_W  = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [IN_W-1:0]    in,
    input  logic               getA,
    input  logic               getB,
    input  logic               is_signed,
    input  logic               start,
    input  logic               putOut,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] Res,
    output logic [15:0]        res_slice,
    output logic [1:0]         dbg_state
);

    localparam int EW     = WIDTH + 2;              // extended operand width
    localparam int PW     = WIDTH + 4;              // accumulator holds +/-2M without overflow
    localparam int N      = WIDTH / 2 + 1;          // Booth digits in an EW-bit multiplier
    localparam int CNT_W  = $clog2(N + 1);
    localparam int SLICES = 2 * WIDTH / 16;
    localparam int PTR_W  = (SLICES > 1) ? $clog2(SLICES) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(N - 1);
    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(SLICES - 1);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t             state, state_nx;
    logic [WIDTH-1:0]   a_reg, b_reg;
    logic [EW-1:0]      m_reg, q_reg;
    logic               qm1;
    logic [PW-1:0]      p_reg;
    logic [CNT_W-1:0]   count;
    logic [PTR_W-1:0]   ptr;
    logic               mode;

    logic               idle_like, accept;
    logic [WIDTH+IN_W-1:0] a_cat, b_cat;
    logic [PW-1:0]      m_ext, pp, p_sum, p_nx;
    logic [EW-1:0]      q_nx;
    logic [2*WIDTH-1:0] prod_nx;

    // Handshake: start is accepted only in IDLE/DONE (busy=0); done stays high from
    // completion until the next accepted start, so a level or a pulse both work.
    assign idle_like = (state == IDLE) || (state == DONE);
    assign accept    = idle_like && start;

    assign a_cat = {in, a_reg};
    assign b_cat = {in, b_reg};

    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE: if (start) state_nx = LOAD;
            LOAD:       state_nx = RUN;
            RUN:        if (count == LAST_CNT) state_nx = DONE;
            default:    state_nx = IDLE;
        endcase
    end

    // Booth recoding of {Q[1],Q[0],q_-1} followed by the 2-bit arithmetic right shift.
    assign m_ext = {{2{m_reg[EW-1]}}, m_reg};
    always_comb begin
        pp = '0;
        case ({q_reg[1:0], qm1})
            3'b001, 3'b010: pp = m_ext;
            3'b011:         pp = m_ext << 1;
            3'b100:         pp = -(m_ext << 1);
            3'b101, 3'b110: pp = -m_ext;
            default:        pp = '0;
        endcase
    end

    assign p_sum   = p_reg + pp;
    assign p_nx    = {{2{p_sum[PW-1]}}, p_sum[PW-1:2]};
    assign q_nx    = {p_sum[1:0], q_reg[EW-1:2]};
    assign prod_nx = {p_nx[WIDTH-3:0], q_nx};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_reg <= '0;
            b_reg <= '0;
            m_reg <= '0;
            q_reg <= '0;
            qm1   <= 1'b0;
            p_reg <= '0;
            count <= '0;
            ptr   <= '0;
            mode  <= 1'b0;
            Res   <= '0;
        end else begin
            if (idle_like) begin
                if (getA) a_reg <= a_cat[WIDTH+IN_W-1:IN_W];
                if (getB) b_reg <= b_cat[WIDTH+IN_W-1:IN_W];
            end
            if (accept) mode <= is_signed;
            case (state)
                LOAD: begin
                    m_reg <= {{2{mode & a_reg[WIDTH-1]}}, a_reg};
                    q_reg <= {{2{mode & b_reg[WIDTH-1]}}, b_reg};
                    qm1   <= 1'b0;
                    p_reg <= '0;
                    count <= '0;
                end
                RUN: begin
                    p_reg <= p_nx;
                    q_reg <= q_nx;
                    qm1   <= q_reg[1];
                    count <= count + CNT_W'(1);
                    if (count == LAST_CNT) begin
                        Res <= prod_nx;
                        ptr <= '0;
                    end
                end
                DONE: begin
                    if (putOut && !start) ptr <= (ptr == LAST_PTR) ? '0 : ptr + PTR_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign busy      = (state == LOAD) || (state == RUN);
    assign done      = (state == DONE);
    assign res_slice = Res[{ptr, 4'b0000} +: 16];
    assign dbg_state = state;

endmodule

// File: tb/tb_radix4_booth_mult_param.sv
// Bench for radix4_booth_mult_param (WIDTH=16, IN_W=8): directed cases plus a random sweep
// checked against a plain-arithmetic product model through an expected queue.
module tb_radix4_booth_mult_param;

    localparam int W    = 16;
    localparam int IN_W = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [IN_W-1:0] in = '0;
    logic            getA = 1'b0, getB = 1'b0, is_signed = 1'b0, start = 1'b0, putOut = 1'b0;
    logic            busy, done;
    logic [2*W-1:0]  Res;
    logic [15:0]     res_slice;
    logic [1:0]      dbg_state;

    radix4_booth_mult_param #(.WIDTH(W), .IN_W(IN_W)) dut (
        .clk(clk), .rst(rst), .in(in), .getA(getA), .getB(getB),
        .is_signed(is_signed), .start(start), .putOut(putOut),
        .busy(busy), .done(done), .Res(Res), .res_slice(res_slice),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic [2*W-1:0] exp_q[$];
    logic [2*W-1:0] last_exp = '0;
    logic [W-1:0]   cur_a = '0, cur_b = '0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic sgn);
        longint pa, pb, pr;
        pa = sgn ? longint'($signed(a)) : longint'(a);
        pb = sgn ? longint'($signed(b)) : longint'(b);
        pr = pa * pb;
        return pr[2*W-1:0];
    endfunction

    // Drivers: every task starts and ends 1 time unit after a rising edge.
    task automatic load_op(input logic [W-1:0] val, input bit to_a, input bit to_b);
        for (int i = 0; i < W / IN_W; i++) begin
            in   = val[i*IN_W +: IN_W];
            getA = to_a;
            getB = to_b;
            @(posedge clk); #1;
        end
        getA = 1'b0;
        getB = 1'b0;
        if (to_a) cur_a = val;
        if (to_b) cur_b = val;
    endtask

    task automatic pulse_put();
        putOut = 1'b1;
        @(posedge clk); #1;
        putOut = 1'b0;
    endtask

    task automatic run_op(input logic sgn, input bit disturb);
        int lat, bcyc;
        logic [2*W-1:0] e;
        exp_q.push_back(model(cur_a, cur_b, sgn));
        is_signed = sgn;
        start     = 1'b1;
        lat = 0;
        bcyc = 0;
        while (lat < 40) begin
            @(posedge clk); #1;
            start = 1'b0;
            getA  = 1'b0;
            getB  = 1'b0;
            lat++;
            if (lat == 2) check_eq("res_hold", Res, last_exp);
            if (busy) bcyc++;
            if (done) break;
            if (disturb && lat >= 3 && lat <= 8) begin
                start = 1'b1;
                getA  = 1'b1;
                getB  = 1'b1;
                in    = IN_W'($urandom);
            end
        end
        check_eq("done_seen", done, 1);
        check_eq("latency", lat, 11);
        check_eq("busy_cycles", bcyc, 10);
        e = exp_q.pop_front();
        check_eq("res", Res, e);
        check_eq("slice0", res_slice, e[15:0]);
        last_exp = e;
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 9))
            0: return 16'h8000;
            1: return 16'hFFFF;
            2: return 16'h0000;
            3: return 16'h7FFF;
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        // Clock/reset
        #12;
        check_eq("rst_res", Res, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_slice", res_slice, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        // Unsigned max * max, then the display window walk
        load_op(16'hFFFF, 1, 0);
        load_op(16'hFFFF, 0, 1);
        run_op(1'b0, 0);
        check_eq("u_ffff_sq", Res, 32'hFFFE0001);
        check_eq("slice_p0", res_slice, 16'h0001);
        pulse_put();
        check_eq("slice_p1", res_slice, 16'hFFFE);
        pulse_put();
        check_eq("slice_wrap", res_slice, 16'h0001);

        // Signed corners (restart from DONE with the same operands)
        run_op(1'b1, 0);
        check_eq("s_m1_sq", Res, 32'h00000001);
        load_op(16'h8000, 1, 1);
        run_op(1'b1, 0);
        check_eq("s_min_sq", Res, 32'h40000000);

        // Chunk order and zero operand
        load_op(16'h1234, 1, 0);
        load_op(16'h0000, 0, 1);
        run_op(1'b0, 0);
        check_eq("zero_b", Res, 0);
        load_op(16'h00FF, 1, 0);
        load_op(16'h0101, 0, 1);
        run_op(1'b0, 0);
        check_eq("u_ff_101", Res, 32'h0000FFFF);

        // start/getA/getB hammered mid-RUN must not disturb anything
        load_op(16'hBEEF, 1, 0);
        load_op(16'h1357, 0, 1);
        run_op(1'b1, 1);
        run_op(1'b0, 0);

        // Async reset in RUN cycle 4
        is_signed = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_eq("mid_rst_busy", busy, 0);
        check_eq("mid_rst_done", done, 0);
        check_eq("mid_rst_res", Res, 0);
        last_exp = '0;
        cur_a = '0;
        cur_b = '0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        load_op(16'hCAFE, 1, 0);
        load_op(16'h0F0F, 0, 1);
        run_op(1'b0, 0);

        // Random sweep, both modes, mixing reloads and back-to-back restarts
        for (int i = 0; i < 1000; i++) begin
            case ($urandom_range(0, 3))
                0: ;
                1: load_op(pick(), 1, 1);
                default: begin
                    load_op(pick(), 1, 0);
                    load_op(pick(), 0, 1);
                end
            endcase
            run_op(1'(($urandom_range(0, 1))), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
